// File: rtl/pmem_loader_if.sv
// ============================================================================
// pmem_loader_if : request, instruction-stream and program-memory bus bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface pmem_loader_if #(
  parameter int AW = 8,
  parameter int DW = 12
);
  // Load request
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  // Instruction stream
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  // Program-memory load and fetch ports
  logic          pm_le;
  logic [AW-1:0] pm_la;
  logic [DW-1:0] pm_li;
  logic          pm_e;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] pm_i;
  // Status
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] checksum;

  // Loader side: it masters the memory ports and the status outputs.
  modport master (
    input  start, base, len, in_valid, in_data, pm_i,
    output in_ready, pm_le, pm_la, pm_li, pm_e, pm_addr,
           core_hold, busy, done, err, checksum
  );

  // Environment side: requester, word source and memory.
  modport slave (
    output start, base, len, in_valid, in_data, pm_i,
    input  in_ready, pm_le, pm_la, pm_li, pm_e, pm_addr,
           core_hold, busy, done, err, checksum
  );
endinterface

`default_nettype wire

// File: rtl/pmem_loader.sv
// ============================================================================
// pmem_loader : streams words into program memory, then reads back and checks
// Revision 1.0
// ============================================================================
`default_nettype none

module pmem_loader #(
  parameter int AW = 8,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  pmem_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    VERIFY = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [AW:0]   MAX_LEN  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [AW:0]   count;
  logic [AW:0]   len_q;
  logic [DW-1:0] rsum;
  logic          pm_le_q;
  logic [AW-1:0] pm_la_q;
  logic [DW-1:0] pm_li_q;
  logic          pm_e_q;
  logic [AW-1:0] pm_addr_q;
  logic          core_hold_q;
  logic          done_q;
  logic          err_q;
  logic [DW-1:0] checksum_q;

  logic          len_ok;
  logic          accept;
  logic [DW-1:0] rsum_next;

  assign len_ok    = (bus.len != '0) && (bus.len <= MAX_LEN);
  assign accept    = bus.in_valid && (state == LOAD);
  assign rsum_next = rsum + bus.pm_i;

  assign bus.in_ready  = (state == LOAD);
  assign bus.busy      = (state != IDLE);
  assign bus.pm_le     = pm_le_q;
  assign bus.pm_la     = pm_la_q;
  assign bus.pm_li     = pm_li_q;
  assign bus.pm_e      = pm_e_q;
  assign bus.pm_addr   = pm_addr_q;
  assign bus.core_hold = core_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.checksum  = checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      waddr       <= '0;
      raddr       <= '0;
      count       <= '0;
      len_q       <= '0;
      rsum        <= '0;
      pm_le_q     <= 1'b0;
      pm_la_q     <= '0;
      pm_li_q     <= '0;
      pm_e_q      <= 1'b0;
      pm_addr_q   <= '0;
      core_hold_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      checksum_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            core_hold_q <= 1'b1;
            if (len_ok) begin
              waddr      <= bus.base;
              raddr      <= bus.base;
              count      <= bus.len;
              len_q      <= bus.len;
              checksum_q <= '0;
              rsum       <= '0;
              err_q      <= 1'b0;
              state      <= LOAD;
            end else begin
              // Illegal length: report immediately, never touch memory.
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            pm_le_q    <= 1'b1;
            pm_la_q    <= waddr;
            pm_li_q    <= bus.in_data;
            waddr      <= waddr + ADDR_ONE;
            checksum_q <= checksum_q + bus.in_data;
            count      <= count - CNT_ONE;
            if (count == CNT_ONE) begin
              state <= FLUSH;
            end
          end else begin
            pm_le_q <= 1'b0;
          end
        end

        FLUSH: begin
          // Last word commits at the end of this cycle; fetch starts next.
          pm_le_q   <= 1'b0;
          count     <= len_q;
          pm_e_q    <= 1'b1;
          pm_addr_q <= raddr;
          raddr     <= raddr + ADDR_ONE;
          state     <= VERIFY;
        end

        VERIFY: begin
          rsum  <= rsum_next;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            // Fold in the final word now so err is valid alongside done.
            pm_e_q <= 1'b0;
            err_q  <= err_q | (rsum_next != checksum_q);
            done_q <= 1'b1;
            state  <= FIN;
          end else begin
            pm_addr_q <= raddr;
            raddr     <= raddr + ADDR_ONE;
          end
        end

        FIN: begin
          done_q      <= 1'b0;
          core_hold_q <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pmem_loader.sv
// ============================================================================
// tb_pmem_loader : table-driven load/verify runs with a write scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pmem_loader;
  localparam int AW = 8;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_loader_if #(.AW(AW), .DW(DW)) bus ();
  pmem_loader #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Program memory model with a corruption hook
  logic [DW-1:0] mem [256];
  logic          corrupt_req = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  assign bus.pm_i = mem[bus.pm_addr];
  always @(posedge clk) begin
    if (bus.pm_le) mem[bus.pm_la] <= bus.pm_li;
    if (corrupt_req) mem[corrupt_addr] <= mem[corrupt_addr] ^ 12'h5A5;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [7:0]  a;
    logic [11:0] d;
  } wr_t;
  wr_t sb[$];

  // Scoreboard: every write on the load port must match the next expected one
  always @(negedge clk) begin
    if (rst_n && bus.pm_le) begin
      wr_t w;
      check("le_with_e", 32'(bus.pm_e), 32'd0);
      check("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check("write_addr", 32'(bus.pm_la), 32'(w.a));
        check("write_data", 32'(bus.pm_li), 32'(w.d));
      end
    end
  end

  typedef struct {
    logic [7:0]       base;
    logic [8:0]       len;
    logic [7:0][11:0] words;
    bit               gap;
    bit               corrupt;
    bit               poke;
    logic [11:0]      exp_sum;
    bit               exp_err;
    int               exp_lat;
  } vec_t;
  vec_t vecs[7];

  logic [DW-1:0] sw [256];

  task automatic run(input logic [7:0] base, input logic [8:0] len, input bit gap,
                     input bit corrupt, input bit poke, input logic [11:0] exp_sum,
                     input bit exp_err, input int exp_lat);
    int t, wi, vi, dones, lat;
    bit phase, flush_next, legal;
    legal = (len != 0) && (len <= 9'd256);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = base;
    bus.len   = len;
    @(negedge clk);
    bus.start = 1'b0;
    t = 1; wi = 0; vi = 0; dones = 0; lat = 0; phase = 1'b0; flush_next = 1'b0;
    while (t < 3000) begin
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          lat = t;
          check("done_err", 32'(bus.err), 32'(exp_err));
          check("done_checksum", 32'(bus.checksum), 32'(exp_sum));
        end
      end
      if (dones == 0 || bus.done) begin
        check("core_hold_run", 32'(bus.core_hold), 32'd1);
        check("busy_run", 32'(bus.busy), 32'd1);
      end
      if (!legal) check("in_ready_illegal", 32'(bus.in_ready), 32'd0);
      if (bus.pm_e) begin
        check("verify_addr", 32'(bus.pm_addr), 32'(8'(base + vi)));
        vi++;
      end
      corrupt_req  = flush_next && corrupt;
      corrupt_addr = 8'(base + 1);
      flush_next   = 1'b0;
      if (poke && (t == 2 || t == exp_lat - 2)) begin
        bus.start = 1'b1;
        bus.base  = 8'h99;
        bus.len   = 9'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (legal && wi < int'(len) && (!gap || !phase)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = sw[wi];
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({8'(base + wi), sw[wi]});
        wi++;
        if (wi == int'(len)) flush_next = 1'b1;
      end
      phase = gap ? ~phase : 1'b0;
      if (dones > 0 && t >= lat + 2) break;
      @(negedge clk);
      t++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    corrupt_req  = 1'b0;
    check("done_pulses", 32'(dones), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("core_hold_after", 32'(bus.core_hold), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("verify_cycles", 32'(vi), legal ? 32'(len) : 32'd0);
    if (legal && !corrupt)
      for (int i = 0; i < int'(len); i++)
        check("mem_content", 32'(mem[8'(base + i)]), 32'(sw[i]));
  endtask

  initial begin
    logic [11:0] sum256;
    bus.start = 1'b0; bus.base = '0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    //            base   len   words (index 7..0)                                             gap cor poke sum    err lat
    vecs[0] = '{8'h10, 9'd3, {12'h0,12'h0,12'h0,12'h0,12'h0,12'hFFF,12'h002,12'h001},          0, 0, 0, 12'h002, 0, 8};
    vecs[1] = '{8'hFE, 9'd4, {12'h0,12'h0,12'h0,12'h0,12'h400,12'h300,12'h200,12'h100},       1, 0, 0, 12'hA00, 0, 13};
    vecs[2] = '{8'h40, 9'd5, {12'h0,12'h0,12'h0,12'h789,12'h456,12'h123,12'hDEF,12'hABC},     0, 1, 0, 12'h5AD, 1, 12};
    vecs[3] = '{8'h00, 9'd1, {12'h0,12'h0,12'h0,12'h0,12'h0,12'h0,12'h0,12'h7FF},             0, 0, 0, 12'h7FF, 0, 4};
    vecs[4] = '{8'h20, 9'd0, {12'h0,12'h0,12'h0,12'h0,12'h0,12'h0,12'h0,12'h0},               0, 0, 0, 12'h7FF, 1, 1};
    vecs[5] = '{8'h20, 9'd257, {12'h0,12'h0,12'h0,12'h0,12'h0,12'h0,12'h0,12'h0},             0, 0, 0, 12'h7FF, 1, 1};
    vecs[6] = '{8'h80, 9'd8, {12'h008,12'h007,12'h006,12'h005,12'h004,12'h003,12'h002,12'h001}, 0, 0, 1, 12'h024, 0, 18};

    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_pm_le", 32'(bus.pm_le), 32'd0);
    check("rst_pm_e", 32'(bus.pm_e), 32'd0);
    check("rst_core_hold", 32'(bus.core_hold), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_checksum", 32'(bus.checksum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 8; i++) sw[i] = vecs[v].words[i];
      run(vecs[v].base, vecs[v].len, vecs[v].gap, vecs[v].corrupt, vecs[v].poke,
          vecs[v].exp_sum, vecs[v].exp_err, vecs[v].exp_lat);
    end

    // Reset in the middle of a 5-word load
    for (int i = 0; i < 5; i++) sw[i] = 12'(12'h111 * (i + 1));
    @(negedge clk);
    bus.start = 1'b1; bus.base = 8'h20; bus.len = 9'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = sw[0];
    sb.push_back({8'h20, sw[0]});
    @(negedge clk);
    bus.in_data = sw[1];
    sb.push_back({8'h21, sw[1]});
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_pm_le", 32'(bus.pm_le), 32'd0);
    check("mid_pm_la", 32'(bus.pm_la), 32'd0);
    check("mid_pm_li", 32'(bus.pm_li), 32'd0);
    check("mid_pm_e", 32'(bus.pm_e), 32'd0);
    check("mid_pm_addr", 32'(bus.pm_addr), 32'd0);
    check("mid_core_hold", 32'(bus.core_hold), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_err", 32'(bus.err), 32'd0);
    check("mid_checksum", 32'(bus.checksum), 32'd0);
    check("mid_mem_first", 32'(mem[8'h20]), 32'(sw[0]));
    check("mid_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sw[0] = 12'h3C3;
    run(8'h05, 9'd1, 1'b0, 1'b0, 1'b0, 12'h3C3, 1'b0, 4);

    // Full 256-word load starting mid-memory
    sum256 = '0;
    for (int i = 0; i < 256; i++) begin
      sw[i] = 12'(i * 37 + 5);
      sum256 = sum256 + sw[i];
    end
    run(8'h33, 9'd256, 1'b0, 1'b0, 1'b0, sum256, 1'b0, 514);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
